// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Holds the response-owner enum and the default starvation limit.
package arb_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } rsp_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear (clear wins).
// Ports: clk_i, rst_i, inc_i, clr_i in; cnt_o out (saturates at LIMIT).
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port.
// Ports: if_* fetch side, d_* data side, mem_* memory side, clk/rst.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  rsp_owner_e rsp_q;
  rsp_owner_e rsp_d;

  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          if_wait;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign if_wait = if_req && !if_gnt;

  // Counts cycles fetch is left waiting; any other cycle clears it.
  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (CW)
  ) u_starve (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (if_wait),
    .clr_i (!if_wait),
    .cnt_o (starve_cnt)
  );

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    rsp_d     = NONE;
    if (!rst) begin
      if (if_req && (starved || !d_req)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      rsp_d    = FETCH;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
      rsp_d     = d_we ? NONE : DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= NONE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Reset drops a read already in flight in its return cycle.
  assign if_rvalid = !rst && (rsp_q == FETCH);
  assign d_rvalid  = !rst && (rsp_q == DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Models a 256-word byte-enabled memory with 1-cycle read latency.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int n_chk;
  int n_err;

  mem_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv_if(input logic req, input logic [31:0] a);
    if_req  = req;
    if_addr = a;
  endtask

  task automatic drv_d(input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    d_req   = req;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  initial begin
    logic [2:0] exp_cnt [6];
    exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    n_chk = 0;
    n_err = 0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i << 2);

    rst = 1'b1;
    drv_if(1'b1, 32'h0);
    drv_d(1'b1, 1'b1, 32'h80, 32'h1234_5678, 4'hF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
    end

    // release; first grant in same cycle, fetch stream
    @(negedge clk);
    rst = 1'b0;
    drv_if(1'b1, 32'h0);
    drv_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("rel_cnt", 32'(dut.starve_cnt), 0);
    check("f0_gnt", if_gnt, 1);
    check("f0_rv", if_rvalid, 0);
    check("f0_en", mem_en, 1);
    check("f0_we", mem_we, 0);
    check("f0_be", 32'(mem_be), 0);
    check("f0_addr", mem_addr, 32'h0);
    @(negedge clk); drv_if(1'b1, 32'h4); #1;
    check("f1_gnt", if_gnt, 1);
    check("f1_rv", if_rvalid, 1);
    check("f1_rd", if_rdata, 32'h1000_0000);
    @(negedge clk); drv_if(1'b1, 32'h8); #1;
    check("f2_gnt", if_gnt, 1);
    check("f2_addr", mem_addr, 32'h8);
    check("f2_rv", if_rvalid, 1);
    check("f2_rd", if_rdata, 32'h1000_0004);
    @(negedge clk); drv_if(1'b0, 32'h0); #1;
    check("f3_gnt", if_gnt, 0);
    check("f3_en", mem_en, 0);
    check("f3_rv", if_rvalid, 1);
    check("f3_rd", if_rdata, 32'h1000_0008);

    // contention: data wins
    @(negedge clk);
    drv_if(1'b1, 32'hC);
    drv_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    check("c0_dgnt", d_gnt, 1);
    check("c0_igen", if_gnt, 0);
    check("c0_addr", mem_addr, 32'h100);
    check("c0_irv", if_rvalid, 0);
    @(negedge clk); drv_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("c1_ignt", if_gnt, 1);
    check("c1_drv", d_rvalid, 1);
    check("c1_drd", d_rdata, 32'h1000_0100);
    check("c1_irv", if_rvalid, 0);
    @(negedge clk); drv_if(1'b0, 32'h0); #1;
    check("c2_irv", if_rvalid, 1);
    check("c2_ird", if_rdata, 32'h1000_000C);
    check("c2_drv", d_rvalid, 0);

    // starvation: fetch forced through on 5th cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv_if(1'b1, 32'h10);
      drv_d(1'b1, 1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0);
      #1;
      check($sformatf("s%0d_cnt", i), 32'(dut.starve_cnt), 32'(exp_cnt[i]));
      check($sformatf("s%0d_ignt", i), if_gnt, (i == 4) ? 1 : 0);
      check($sformatf("s%0d_dgnt", i), d_gnt, (i == 4) ? 0 : 1);
      if (i == 5) begin
        check("s5_irv", if_rvalid, 1);
        check("s5_ird", if_rdata, 32'h1000_0010);
      end
    end
    @(negedge clk);
    drv_if(1'b0, 32'h0);
    drv_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("s6_drv", d_rvalid, 1);
    check("s6_drd", d_rdata, 32'h1000_0034);

    // store, then load back
    @(negedge clk); drv_d(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011); #1;
    check("w_dgnt", d_gnt, 1);
    check("w_we", mem_we, 1);
    check("w_be", 32'(mem_be), 32'h3);
    check("w_wd", mem_wdata, 32'hDEAD_BEEF);
    check("w_addr", mem_addr, 32'h200);
    @(negedge clk); drv_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h0); #1;
    check("w_norv", d_rvalid, 0);
    check("l_dgnt", d_gnt, 1);
    check("l_we", mem_we, 0);
    @(negedge clk); drv_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("l_drv", d_rvalid, 1);
    check("l_lo", 32'(d_rdata[15:0]), 32'hBEEF);
    check("l_drd", d_rdata, 32'h1000_BEEF);

    // reset during outstanding fetch
    @(negedge clk); drv_if(1'b1, 32'h40); #1;
    check("r0_ignt", if_gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    drv_d(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    #1;
    check("r1_irv", if_rvalid, 0);
    check("r1_ignt", if_gnt, 0);
    check("r1_dgnt", d_gnt, 0);
    check("r1_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b0;
    drv_if(1'b1, 32'h44);
    drv_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("r2_irv", if_rvalid, 0);
    check("r2_cnt", 32'(dut.starve_cnt), 0);
    check("r2_ignt", if_gnt, 1);
    @(negedge clk); drv_if(1'b0, 32'h0); #1;
    check("r3_irv", if_rvalid, 1);
    check("r3_ird", if_rdata, 32'h1000_0044);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 if_req  in  1  fetch read request.
REQ-007 if_addr  in  ADDR_WIDTH  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DATA_WIDTH  fetch read data.
REQ-011 d_req  in  1  data (load/store) request.
REQ-012 d_we  in  1  data request is a write.
REQ-013 d_addr  in  ADDR_WIDTH  data address.
REQ-014 d_wdata  in  DATA_WIDTH  store data.
REQ-015 d_be  in  4  store byte enables.
REQ-016 d_gnt, d_rvalid  out  1 each  data accepted / load data valid.
REQ-017 d_rdata  out  DATA_WIDTH  load data.
REQ-018 mem_en, mem_we  out  1 each  memory access strobe / write strobe.
REQ-019 mem_addr, mem_wdata, mem_be  out  ADDR_WIDTH, DATA_WIDTH, 4  memory command fields.
REQ-020 mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read strobe.

Function
REQ-021 At most one of if_gnt, d_gnt SHALL be high per cycle; grants are combinational from current requests and state.
REQ-022 A granted request SHALL drive mem_en=1 and its addr/we/wdata/be onto the mem_* ports in the same cycle; a fetch SHALL drive mem_we=0 and mem_be=4'b0000.
REQ-023 With no grant, mem_en and mem_we SHALL be 0.
REQ-024 Priority: data over fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-025 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0, and SHALL clear when if_gnt=1 or if_req=0.
REQ-026 Response-owner register rsp_q states: NONE, FETCH, DATA; next state = FETCH on a fetch grant, DATA on a data read grant, else NONE (including a data write grant).
REQ-027 In a cycle with rsp_q=FETCH, if_rvalid=1 and if_rdata=mem_rdata; with rsp_q=DATA, d_rvalid=1 and d_rdata=mem_rdata; otherwise both rvalid=0.
REQ-028 Read latency SHALL be exactly 1 cycle grant-to-rvalid; a new grant may issue in the same cycle as a returning response (full throughput, one access per cycle).
REQ-029 Writes SHALL complete at grant; no d_rvalid for writes.
REQ-030 Requesters hold req and fields stable until gnt; the arbiter does not buffer requests.
REQ-031 rdata outputs SHALL be don't-care when the matching rvalid=0; the bench checks them only under rvalid.

Reset
REQ-032 While rst=1: if_gnt, d_gnt, mem_en, mem_we=0; next edge sets rsp_q=NONE, starve_cnt=0.
REQ-033 Reset asserted during an outstanding read SHALL drop it: no rvalid in the cycle after reset.
REQ-034 First grant possible in the cycle rst deasserts.

Structure
REQ-035 Shared package arb_pkg SHALL hold the rsp_owner_e enum (NONE/FETCH/DATA) and the default STARVE_LIMIT constant.
REQ-036 One sub-module, arb_starve_ctr (saturating counter with clear), is natural; grant logic and rsp_q stay in mem_arbiter.

Verification
REQ-037 Fetch only: if_req=1, addr 0x0,0x4,0x8 each cycle -> if_gnt=1 every cycle, if_rvalid one cycle later with mem contents, back-to-back.
REQ-038 Contention: if_req=d_req=1 (load 0x100) -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1, d_rdata=mem[0x100], if_rvalid=0.
REQ-039 Starvation: d_req held high 6 cycles with if_req high, STARVE_LIMIT=4 -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycle 5.
REQ-040 Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 same cycle, no d_rvalid; later load returns 0x0000BEEF in low half.
REQ-041 Reset mid-read: fetch granted, rst=1 next cycle -> if_rvalid=0, all grants 0, starve_cnt=0 after release.
